// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates a single-port memory between instruction fetch and load/store, with fetch anti-starvation and response timeout.
// Latency: request sampled in IDLE -> mem_req_valid next cycle -> requester data_valid one cycle after mem_data_valid (2 cycles minimum).
// Backpressure: requesters hold req_valid until their data_valid pulse; new requests wait while a transaction is in flight.
module mem_port_arbiter #(
    parameter int MEM_DEPTH    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    // instruction-fetch side
    input  logic                          if_req_valid,
    input  logic [$clog2(MEM_DEPTH)-1:0]  if_addr,
    output logic [DATA_WIDTH-1:0]         if_rdata,
    output logic                          if_data_valid,
    // load/store side
    input  logic                          ls_req_valid,
    input  logic                          ls_we,
    input  logic [$clog2(MEM_DEPTH)-1:0]  ls_addr,
    input  logic [DATA_WIDTH-1:0]         ls_wdata,
    output logic [DATA_WIDTH-1:0]         ls_rdata,
    output logic                          ls_data_valid,
    // shared memory side
    output logic                          mem_req_valid,
    output logic                          mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_data_valid,
    // status
    output logic                          busy,
    output logic                          grant_id,
    output logic                          bus_err
);

    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int SW         = $clog2(STARVE_LIMIT + 1);
    // Keep the timeout counter at least one bit wide even when the timeout is disabled.
    localparam int TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_LAST    = TW'(TO_LAST_I);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           streak_q, streak_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;

    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    busy_q, busy_d;
    logic                    gid_q, gid_d;
    logic                    if_dv_q, if_dv_d;
    logic                    ls_dv_q, ls_dv_d;
    logic [DATA_WIDTH-1:0]   if_rd_q, if_rd_d;
    logic [DATA_WIDTH-1:0]   ls_rd_q, ls_rd_d;
    logic                    err_q, err_d;

    logic                    grant_ls;
    logic                    timed_out;

    // Load/store wins unless fetch is also waiting and has been passed over STARVE_LIMIT times in a row.
    assign grant_ls  = ls_req_valid && !(if_req_valid && (streak_q == STREAK_MAX));
    assign timed_out = (TIMEOUT != 0) && (tcnt_q == TO_LAST);

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tcnt_d      = tcnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        gid_d       = gid_q;
        if_dv_d     = 1'b0;
        ls_dv_d     = 1'b0;
        err_d       = 1'b0;
        if_rd_d     = if_rd_q;
        ls_rd_d     = ls_rd_q;

        case (state_q)
            IDLE: begin
                if (if_req_valid || ls_req_valid) begin
                    state_d   = BUSY;
                    busy_d    = 1'b1;
                    mem_req_d = 1'b1;
                    tcnt_d    = '0;
                    gid_d     = grant_ls;
                    if (grant_ls) begin
                        mem_addr_d  = ls_addr;
                        mem_we_d    = ls_we;
                        mem_wdata_d = ls_wdata;
                        // Count only the grants that actually made a waiting fetch lose.
                        if (if_req_valid) begin
                            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                        end else begin
                            streak_d = '0;
                        end
                    end else begin
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end
                end
            end

            BUSY: begin
                if (mem_data_valid) begin
                    // A response in the last allowed cycle still counts as a normal completion.
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (gid_q) begin
                        ls_dv_d = 1'b1;
                        ls_rd_d = mem_rdata;
                    end else begin
                        if_dv_d = 1'b1;
                        if_rd_d = mem_rdata;
                    end
                end else if (timed_out) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (gid_q) begin
                        ls_dv_d = 1'b1;
                        ls_rd_d = '0;
                    end else begin
                        if_dv_d = 1'b1;
                        if_rd_d = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tcnt_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            gid_q       <= 1'b0;
            if_dv_q     <= 1'b0;
            ls_dv_q     <= 1'b0;
            if_rd_q     <= '0;
            ls_rd_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tcnt_q      <= tcnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            gid_q       <= gid_d;
            if_dv_q     <= if_dv_d;
            ls_dv_q     <= ls_dv_d;
            if_rd_q     <= if_rd_d;
            ls_rd_q     <= ls_rd_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_valid = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign busy          = busy_q;
    assign grant_id      = gid_q;
    assign if_data_valid = if_dv_q;
    assign ls_data_valid = ls_dv_q;
    assign if_rdata      = if_rd_q;
    assign ls_rdata      = ls_rd_q;
    assign bus_err       = err_q;

endmodule
